vend_ctrl_multi: RTL

Parametrised successor to the team's single-price 5/10-rupee vending FSM. Accepts 5, 10 and 20 rupee coins and accumulates credit up to a ceiling. Sells one of NUM_PROD products, each with its own compile-time price, and supports cancel/refund. Change is paid out one coin per handshake, so the controller can drive a slow mechanical coin hopper.

---
 rtl/vend_ctrl_multi.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vend_ctrl_multi.sv
// Multi-product coin vending controller: 5/10/20 coins, per-product prices, cancel/refund,
// change paid out one coin per hopper handshake. All outputs registered; buy-to-vend latency 1 cycle.
module vend_ctrl_multi #(
    parameter int NUM_PROD   = 4,
    parameter int SEL_W      = 2,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 100,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {8'd40, 8'd25, 8'd20, 8'd15}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          in,
    input  logic                buy,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    output logic                out,
    output logic [SEL_W-1:0]    vend_sel,
    output logic                reject,
    output logic                deny,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          change,
    output logic                change_valid,
    input  logic                change_ack,
    output logic                busy
);

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_out;
    logic [SEL_W-1:0]    r_vend_sel;
    logic                r_reject;
    logic                r_deny;
    logic [1:0]          r_change;
    logic                r_change_valid;
    logic                r_busy;

    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W:0]   w_coin_val;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_ok;
    logic                w_sel_ok;
    logic                w_can_buy;
    logic [CREDIT_W-1:0] w_chg_amt;
    logic [CREDIT_W-1:0] w_chg_rem;

    // Greedy coin choice for the hopper: tens first, a single five to finish.
    function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] amt);
        return (amt >= CREDIT_W'(10)) ? 2'b10 : 2'b01;
    endfunction

    always_comb begin
        w_price = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (32'(sel) == 32'(i)) w_price = PRICES[i*CREDIT_W +: CREDIT_W];
        end
    end

    always_comb begin
        case (in)
            2'b01:   w_coin_val = (CREDIT_W+1)'(5);
            2'b10:   w_coin_val = (CREDIT_W+1)'(10);
            2'b11:   w_coin_val = (CREDIT_W+1)'(20);
            default: w_coin_val = '0;
        endcase
    end

    // Sum carries one extra bit so an over-ceiling coin can never wrap into range.
    assign w_sum     = {1'b0, r_credit} + w_coin_val;
    assign w_coin_ok = (w_sum <= MAX_C);
    assign w_sel_ok  = (32'(sel) < 32'(NUM_PROD));
    assign w_can_buy = w_sel_ok && (r_credit >= w_price);
    assign w_chg_amt = (r_change == 2'b10) ? CREDIT_W'(10) : CREDIT_W'(5);
    assign w_chg_rem = r_credit - w_chg_amt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_out          <= 1'b0;
            r_vend_sel     <= '0;
            r_reject       <= 1'b0;
            r_deny         <= 1'b0;
            r_change       <= 2'b00;
            r_change_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_out    <= 1'b0;
            r_reject <= 1'b0;
            r_deny   <= 1'b0;
            case (r_state)
                S_IDLE, S_CREDIT: begin
                    if (cancel) begin
                        r_reject <= (in != 2'b00);
                        if (r_credit != '0) begin
                            r_state        <= S_CHANGE;
                            r_change       <= pick_coin(r_credit);
                            r_change_valid <= 1'b1;
                            r_busy         <= 1'b1;
                        end
                    end else if (buy) begin
                        r_reject <= (in != 2'b00);
                        if (w_can_buy) begin
                            r_state    <= S_VEND;
                            r_out      <= 1'b1;
                            r_vend_sel <= sel;
                            r_credit   <= r_credit - w_price;
                            r_busy     <= 1'b1;
                        end else begin
                            r_deny <= 1'b1;
                        end
                    end else if (in != 2'b00) begin
                        if (w_coin_ok) begin
                            r_credit <= w_sum[CREDIT_W-1:0];
                            r_state  <= S_CREDIT;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end
                S_VEND: begin
                    r_reject <= (in != 2'b00);
                    r_deny   <= buy;
                    if (r_credit != '0) begin
                        r_state        <= S_CHANGE;
                        r_change       <= pick_coin(r_credit);
                        r_change_valid <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_CHANGE: begin
                    r_reject <= (in != 2'b00);
                    r_deny   <= buy;
                    if (change_ack && r_change_valid) begin
                        r_credit <= w_chg_rem;
                        if (w_chg_rem == '0) begin
                            r_state        <= S_IDLE;
                            r_change       <= 2'b00;
                            r_change_valid <= 1'b0;
                            r_busy         <= 1'b0;
                        end else begin
                            r_change <= pick_coin(w_chg_rem);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out          = r_out;
    assign vend_sel     = r_vend_sel;
    assign reject       = r_reject;
    assign deny         = r_deny;
    assign credit       = r_credit;
    assign change       = r_change;
    assign change_valid = r_change_valid;
    assign busy         = r_busy;

endmodule
